reg_file_alu_seq: RTL and testbench

//  Micro-sequencer for the reg_file_alu datapath (16x8 regfile + 2-bit ALU, sync write of ALUResult to WA).

---
 rtl/reg_file_alu_seq_pkg.sv | 56 +++++
 rtl/reg_file_alu.sv | 44 ++++
 rtl/reg_file_alu_seq_dec.sv | 34 +++
 rtl/reg_file_alu_seq.sv | 156 +++++++++++++++
 tb/tb_reg_file_alu_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_alu_seq_pkg.sv
// Shared types for the reg_file_alu micro-sequencer: opcodes, ALU selects, FSM states, decode bundle.
// Instruction layout is {op[3:0], rd, rs1, imm}; the helpers give field LSB positions for any width.
package reg_file_alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_AND  = 4'd1,
        OP_OR   = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_ANDI = 4'd5,
        OP_ORI  = 4'd6,
        OP_ADDI = 4'd7,
        OP_SUBI = 4'd8,
        OP_LDI  = 4'd9,
        OP_CMP  = 4'd10
    } opcode_e;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_EXEC = 2'd2
    } state_e;

    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluctl;
        logic       wr_en;
        logic       two_phase;
        logic       is_illegal;
    } dec_t;

    localparam int OP_W = 4;

    function automatic int instr_w(input int aw, input int dw);
        return OP_W + 2 * aw + dw;
    endfunction

    function automatic int op_lsb(input int aw, input int dw);
        return dw + 2 * aw;
    endfunction

    function automatic int rd_lsb(input int aw, input int dw);
        return dw + aw;
    endfunction

    function automatic int rs1_lsb(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/reg_file_alu.sv
// Datapath: 2^ADDR_W x DATA_W register file with two async reads, a 2-bit ALU and sync write of the result.
// ALUResult is combinational from the read ports; write lands on the rising edge when RegWrite is high.
module reg_file_alu
    import reg_file_alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA,
    input  logic              RegWrite,
    input  logic              ALUSrc,
    input  logic [1:0]        ALUControl,
    input  logic [DATA_W-1:0] external_data_in,
    output logic [DATA_W-1:0] ALUResult
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    assign w_a = r_mem[RA1];
    assign w_b = ALUSrc ? external_data_in : r_mem[RA2];

    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            ALU_AND: ALUResult = w_a & w_b;
            ALU_OR:  ALUResult = w_a | w_b;
            ALU_ADD: ALUResult = w_a + w_b;
            ALU_SUB: ALUResult = w_a - w_b;
            default: ALUResult = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RegWrite) begin
            r_mem[WA] <= ALUResult;
        end
    end

endmodule

// File: rtl/reg_file_alu_seq_dec.sv
// Opcode decoder: op -> ALU operand source, ALU function, write enable, two-phase and illegal flags.
// Purely combinational, zero latency; no handshake of its own.
module reg_file_alu_seq_dec
    import reg_file_alu_seq_pkg::*;
(
    input  logic [3:0] i_op,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_op)
            OP_NOP:  o_dec.aluctl = ALU_AND;
            OP_AND:  begin o_dec.aluctl = ALU_AND; o_dec.wr_en = 1'b1; end
            OP_OR:   begin o_dec.aluctl = ALU_OR;  o_dec.wr_en = 1'b1; end
            OP_ADD:  begin o_dec.aluctl = ALU_ADD; o_dec.wr_en = 1'b1; end
            OP_SUB:  begin o_dec.aluctl = ALU_SUB; o_dec.wr_en = 1'b1; end
            OP_ANDI: begin o_dec.aluctl = ALU_AND; o_dec.wr_en = 1'b1; o_dec.alusrc = 1'b1; end
            OP_ORI:  begin o_dec.aluctl = ALU_OR;  o_dec.wr_en = 1'b1; o_dec.alusrc = 1'b1; end
            OP_ADDI: begin o_dec.aluctl = ALU_ADD; o_dec.wr_en = 1'b1; o_dec.alusrc = 1'b1; end
            OP_SUBI: begin o_dec.aluctl = ALU_SUB; o_dec.wr_en = 1'b1; o_dec.alusrc = 1'b1; end
            // LDI second phase is an ORI of the freshly cleared rd with the immediate
            OP_LDI: begin
                o_dec.aluctl    = ALU_OR;
                o_dec.wr_en     = 1'b1;
                o_dec.alusrc    = 1'b1;
                o_dec.two_phase = 1'b1;
            end
            OP_CMP:  o_dec.aluctl = ALU_SUB;
            default: o_dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_file_alu_seq.sv
// Micro-sequencer for reg_file_alu: one instruction per cycle sustained (LDI takes two), result one edge after EXEC.
// instr_ready is low during the LDI clear phase and during reset; a stalled producer must hold instr stable.
module reg_file_alu_seq
    import reg_file_alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [4+2*ADDR_W+DATA_W-1:0] instr,
    output logic [ADDR_W-1:0]            RA1,
    output logic [ADDR_W-1:0]            RA2,
    output logic [ADDR_W-1:0]            WA,
    output logic [DATA_W-1:0]            external_data_in,
    output logic                         RegWrite,
    output logic                         ALUSrc,
    output logic [1:0]                   ALUControl,
    input  logic [DATA_W-1:0]            ALUResult,
    output logic [DATA_W-1:0]            res_data,
    output logic                         res_valid,
    output logic                         illegal,
    output logic                         busy,
    output logic [CNT_W-1:0]             instr_count
);

    localparam int IW      = instr_w(ADDR_W, DATA_W);
    localparam int OP_LSB  = op_lsb(ADDR_W, DATA_W);
    localparam int RD_LSB  = rd_lsb(ADDR_W, DATA_W);
    localparam int RS1_LSB = rs1_lsb(DATA_W);

    state_e            r_state;
    state_e            w_next;
    logic [IW-1:0]     r_ir;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_valid;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_cnt;

    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_rd;
    logic [ADDR_W-1:0] w_rs1;
    logic [ADDR_W-1:0] w_rs2;
    logic [DATA_W-1:0] w_imm;
    logic              w_hs;
    logic              w_in_ldi;
    dec_t              w_dec;

    assign w_op  = r_ir[OP_LSB +: 4];
    assign w_rd  = r_ir[RD_LSB +: ADDR_W];
    assign w_rs1 = r_ir[RS1_LSB +: ADDR_W];
    assign w_imm = r_ir[DATA_W-1:0];
    assign w_rs2 = w_imm[ADDR_W-1:0];

    reg_file_alu_seq_dec u_dec (
        .i_op  (w_op),
        .o_dec (w_dec)
    );

    // Ready is forced low while reset is held so nothing appears accepted during reset
    assign instr_ready = ~reset & ((r_state == ST_IDLE) | (r_state == ST_EXEC));
    assign w_hs        = instr_valid & instr_ready;
    assign w_in_ldi    = (instr[OP_LSB +: 4] == OP_LDI);
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_EXEC: begin
                if (w_hs) begin
                    w_next = w_in_ldi ? ST_CLR : ST_EXEC;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CLR:  w_next = ST_EXEC;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        RA1              = '0;
        RA2              = '0;
        WA               = '0;
        external_data_in = '0;
        RegWrite         = 1'b0;
        ALUSrc           = 1'b0;
        ALUControl       = ALU_AND;
        case (r_state)
            // LDI clear phase: rd - rd written back to rd
            ST_CLR: begin
                RA1        = w_rd;
                RA2        = w_rd;
                WA         = w_rd;
                ALUControl = ALU_SUB;
                RegWrite   = 1'b1;
            end
            ST_EXEC: begin
                RA1              = w_dec.two_phase ? w_rd : w_rs1;
                RA2              = w_dec.two_phase ? '0 : w_rs2;
                WA               = w_rd;
                ALUSrc           = w_dec.alusrc;
                ALUControl       = w_dec.aluctl;
                RegWrite         = w_dec.wr_en;
                external_data_in = w_dec.alusrc ? w_imm : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir <= '0;
        end else if (w_hs) begin
            r_ir <= instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_res_valid <= 1'b0;
            r_illegal   <= 1'b0;
            if (r_state == ST_EXEC) begin
                r_res_data <= ALUResult;
                if (w_dec.is_illegal) begin
                    r_illegal <= 1'b1;
                end else begin
                    r_res_valid <= 1'b1;
                    r_cnt       <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign res_data    = r_res_data;
    assign res_valid   = r_res_valid;
    assign illegal     = r_illegal;
    assign instr_count = r_cnt;

endmodule

// File: tb/tb_reg_file_alu_seq.sv
// Bench: two sequencer+datapath pairs fed in lockstep (CNT_W=16 and CNT_W=2); vector table plus corner sequences.
module tb_reg_file_alu_seq;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [19:0] instr;

    logic        rdy1, rdy2;
    logic [3:0]  ra1_1, ra2_1, wa_1, ra1_2, ra2_2, wa_2;
    logic [7:0]  ext_1, ext_2, alu_1, alu_2, res_1, res_2;
    logic        RegWrite, rw_2, src_1, src_2;
    logic [1:0]  ctl_1, ctl_2;
    logic        res_valid, rv_2, illegal, ill_2, busy, busy_2;
    logic [15:0] instr_count;
    logic [1:0]  cnt2;

    reg_file_alu_seq #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) u_seq (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy1), .instr(instr),
        .RA1(ra1_1), .RA2(ra2_1), .WA(wa_1), .external_data_in(ext_1), .RegWrite(RegWrite),
        .ALUSrc(src_1), .ALUControl(ctl_1), .ALUResult(alu_1), .res_data(res_1),
        .res_valid(res_valid), .illegal(illegal), .busy(busy), .instr_count(instr_count)
    );
    reg_file_alu #(.DATA_W(8), .ADDR_W(4)) u_dp (
        .clk(clk), .RA1(ra1_1), .RA2(ra2_1), .WA(wa_1), .RegWrite(RegWrite), .ALUSrc(src_1),
        .ALUControl(ctl_1), .external_data_in(ext_1), .ALUResult(alu_1)
    );
    reg_file_alu_seq #(.DATA_W(8), .ADDR_W(4), .CNT_W(2)) u_seq2 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy2), .instr(instr),
        .RA1(ra1_2), .RA2(ra2_2), .WA(wa_2), .external_data_in(ext_2), .RegWrite(rw_2),
        .ALUSrc(src_2), .ALUControl(ctl_2), .ALUResult(alu_2), .res_data(res_2),
        .res_valid(rv_2), .illegal(ill_2), .busy(busy_2), .instr_count(cnt2)
    );
    reg_file_alu #(.DATA_W(8), .ADDR_W(4)) u_dp2 (
        .clk(clk), .RA1(ra1_2), .RA2(ra2_2), .WA(wa_2), .RegWrite(rw_2), .ALUSrc(src_2),
        .ALUControl(ctl_2), .external_data_in(ext_2), .ALUResult(alu_2)
    );

    typedef struct packed {
        logic [19:0] ins;
        logic [7:0]  res;
        logic        ill;
        logic        wr;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    int   cyc = 0;
    logic log_en = 1'b0;
    logic [7:0] log_q[$];
    int   stamp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (log_en && res_valid) begin
            log_q.push_back(res_1);
            stamp_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    function automatic logic [19:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [7:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [19:0] ins);
        int n;
        n = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        while (!rdy1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!rdy1) chk("send_timeout", 32'(rdy1), 32'd1);
        @(posedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic saw_wr;
        logic got;
        logic is_ldi;
        saw_wr = 1'b0;
        got    = 1'b0;
        is_ldi = (v.ins[19:16] == 4'd9);
        send(v.ins);
        @(negedge clk);
        instr_valid = 1'b0;
        if (is_ldi) chk({nm, "_clr_ready"}, 32'(rdy1), 32'd0);
        for (int k = 0; k < 6 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (RegWrite) saw_wr = 1'b1;
            if (res_valid || illegal) got = 1'b1;
        end
        if (!v.ill) exp_cnt++;
        if (!got) begin
            chk({nm, "_timeout"}, 32'(got), 32'd1);
        end else begin
            chk({nm, "_illegal"}, 32'(illegal), 32'(v.ill));
            chk({nm, "_res_valid"}, 32'(res_valid), 32'(!v.ill));
            if (!v.ill) chk({nm, "_res_data"}, 32'(res_1), 32'(v.res));
            chk({nm, "_regwrite"}, 32'(saw_wr), 32'(v.wr));
            chk({nm, "_count"}, 32'(instr_count), 32'(exp_cnt));
            chk({nm, "_count2"}, 32'(cnt2), 32'(exp_cnt % 4));
        end
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;

        vt.push_back(vec_t'({enc(4'd9,  4'd5,  4'd0, 8'h05), 8'h05, 1'b0, 1'b1}));  // LDI r5,#5
        vt.push_back(vec_t'({enc(4'd9,  4'd4,  4'd0, 8'h04), 8'h04, 1'b0, 1'b1}));  // LDI r4,#4
        vt.push_back(vec_t'({enc(4'd3,  4'd1,  4'd5, 8'h04), 8'h09, 1'b0, 1'b1}));  // ADD r1,r5,r4
        vt.push_back(vec_t'({enc(4'd6,  4'd15, 4'd1, 8'h00), 8'h09, 1'b0, 1'b1}));  // read r1
        vt.push_back(vec_t'({enc(4'd4,  4'd2,  4'd4, 8'h05), 8'hFF, 1'b0, 1'b1}));  // SUB r2,r4,r5
        vt.push_back(vec_t'({enc(4'd7,  4'd2,  4'd2, 8'h01), 8'h00, 1'b0, 1'b1}));  // ADDI r2,r2,#1
        vt.push_back(vec_t'({enc(4'd6,  4'd15, 4'd2, 8'h00), 8'h00, 1'b0, 1'b1}));  // read r2
        vt.push_back(vec_t'({enc(4'd1,  4'd6,  4'd5, 8'h04), 8'h04, 1'b0, 1'b1}));  // AND
        vt.push_back(vec_t'({enc(4'd2,  4'd6,  4'd5, 8'h04), 8'h05, 1'b0, 1'b1}));  // OR
        vt.push_back(vec_t'({enc(4'd5,  4'd6,  4'd5, 8'h0C), 8'h04, 1'b0, 1'b1}));  // ANDI
        vt.push_back(vec_t'({enc(4'd8,  4'd6,  4'd4, 8'h05), 8'hFF, 1'b0, 1'b1}));  // SUBI
        vt.push_back(vec_t'({enc(4'd10, 4'd4,  4'd5, 8'h04), 8'h01, 1'b0, 1'b0}));  // CMP r5,r4
        vt.push_back(vec_t'({enc(4'd6,  4'd15, 4'd5, 8'h00), 8'h05, 1'b0, 1'b1}));  // read r5
        vt.push_back(vec_t'({enc(4'd6,  4'd15, 4'd4, 8'h00), 8'h04, 1'b0, 1'b1}));  // read r4
        vt.push_back(vec_t'({enc(4'd15, 4'd4,  4'd5, 8'h04), 8'h00, 1'b1, 1'b0}));  // op 15
        vt.push_back(vec_t'({enc(4'd11, 4'd4,  4'd5, 8'h00), 8'h00, 1'b1, 1'b0}));  // op 11
        vt.push_back(vec_t'({enc(4'd0,  4'd4,  4'd5, 8'h04), 8'h04, 1'b0, 1'b0}));  // NOP
        vt.push_back(vec_t'({enc(4'd6,  4'd15, 4'd4, 8'h00), 8'h04, 1'b0, 1'b1}));  // read r4

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(rdy1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_ready", 32'(rdy1), 32'd1);

        for (int i = 0; i < vt.size(); i++) begin
            run_vec(vt[i], $sformatf("v%0d", i));
        end

        // LDI followed by back-to-back ADDIs with valid held high
        @(negedge clk);
        log_en = 1'b1;
        send(enc(4'd9, 4'd3, 4'd0, 8'h01));
        for (int i = 0; i < 4; i++) send(enc(4'd7, 4'd3, 4'd3, 8'h01));
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (6) @(negedge clk);
        log_en = 1'b0;
        exp_cnt += 5;
        chk("b2b_results", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < log_q.size() && i < 5; i++) begin
            chk($sformatf("b2b_data%0d", i), 32'(log_q[i]), 32'(i + 1));
            chk($sformatf("b2b_cycle%0d", i), 32'(stamp_q[i] - stamp_q[0]), 32'(i));
        end
        chk("b2b_count", 32'(instr_count), 32'(exp_cnt));

        // Reset arriving in the clear phase of an LDI must not commit the write
        run_vec(vec_t'({enc(4'd9, 4'd7, 4'd0, 8'h03), 8'h03, 1'b0, 1'b1}), "ldi_r7");
        send(enc(4'd9, 4'd7, 4'd0, 8'h0A));
        @(negedge clk);
        instr_valid = 1'b0;
        chk("clr_regwrite", 32'(RegWrite), 32'd1);
        chk("clr_wa", 32'(wa_1), 32'd7);
        chk("clr_ready", 32'(rdy1), 32'd0);
        reset = 1'b1;
        #1;
        chk("midrst_regwrite", 32'(RegWrite), 32'd0);
        chk("midrst_wa", 32'(wa_1), 32'd0);
        chk("midrst_ready", 32'(rdy1), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(instr_count), 32'd0);
        chk("midrst_count2", 32'(cnt2), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = 0;
        run_vec(vec_t'({enc(4'd6, 4'd15, 4'd7, 8'h00), 8'h03, 1'b0, 1'b1}), "r7_kept");

        // Five legal retirements since reset: the 2-bit counter wraps to 1
        for (int i = 0; i < 4; i++) begin
            run_vec(vec_t'({enc(4'd0, 4'd0, 4'd7, 8'h07), 8'h03, 1'b0, 1'b0}), $sformatf("nop%0d", i));
        end
        chk("wrap_count2", 32'(cnt2), 32'd1);
        chk("wrap_count", 32'(instr_count), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
